// File: rtl/sd_card_spi.sv
// rtl/sd_card_spi.sv - SPI mode-0 SD card responder (SDHC) with block reads from a byte-wide memory
// Decodes 6-byte commands, answers CMD0/8/55/ACMD41/58/17 and streams 512-byte blocks.
module sd_card_spi #(
   parameter int ADDR_W     = 24,
   parameter int INIT_POLLS = 2,
   parameter int NAC        = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              spi_cs,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_q,
   output logic              card_idle,
   output logic [5:0]        last_cmd
);

   localparam int PW    = (INIT_POLLS < 1) ? 1 : $clog2(INIT_POLLS + 1);
   localparam int ARG_W = (ADDR_W - 9 > 8) ? ADDR_W - 9 : 8;

   typedef enum logic [2:0] {RX_CMD, NCR, RESP, GAP, DATA, CRC} state_t;
   state_t state, state_nx;

   logic [1:0]       cs_s, sclk_s, mosi_s;
   logic             sclk_q;
   logic [6:0]       rx_sr;
   logic [2:0]       bit_cnt;
   logic             load;
   logic [7:0]       tx_sr, tx_next, txn_nx;
   logic [9:0]       cnt, cnt_nx;
   logic [5:0]       cmd_r;
   logic [ARG_W-1:0] arg_r;
   logic [7:0]       resp_buf [5];
   logic [2:0]       resp_len;
   logic             app, data_go;
   logic [PW-1:0]    polls;
   logic [9:0]       rd_idx;
   logic             cap;

   logic             active, rise, fall, byte_done, decode;
   logic [7:0]       rx_byte, r1;
   logic [7:0]       dec_b [5];
   logic [2:0]       dec_len;
   logic             idle_nx, app_nx, go_nx;
   logic [PW-1:0]    polls_nx;

   assign active    = ~cs_s[1];
   assign rise      = active & sclk_s[1] & ~sclk_q;
   assign fall      = active & ~sclk_s[1] & sclk_q;
   assign rx_byte   = {rx_sr, mosi_s[1]};
   assign byte_done = rise & (bit_cnt == 3'd7);
   assign spi_miso  = tx_sr[7];
   assign r1        = {7'd0, card_idle};

   // Response and card-state update for the command held in cmd_r/arg_r
   always_comb begin
      for (int k = 0; k < 5; k++) dec_b[k] = 8'h00;
      dec_len  = 3'd1;
      idle_nx  = card_idle;
      app_nx   = 1'b0;
      polls_nx = polls;
      go_nx    = 1'b0;
      case (cmd_r)
         6'd0: begin
            dec_b[0] = 8'h01;
            idle_nx  = 1'b1;
            polls_nx = PW'(INIT_POLLS);
         end
         6'd8: begin
            dec_b[0] = r1;
            dec_b[3] = 8'h01;
            dec_b[4] = arg_r[7:0];
            dec_len  = 3'd5;
         end
         6'd55: begin
            dec_b[0] = r1;
            app_nx   = 1'b1;
         end
         6'd41: begin
            if (!app) begin
               dec_b[0] = r1 | 8'h04;
            end else if (polls != '0) begin
               dec_b[0] = 8'h01;
               polls_nx = polls - PW'(1);
            end else begin
               dec_b[0] = 8'h00;
               idle_nx  = 1'b0;
            end
         end
         6'd58: begin
            dec_b[0] = r1;
            dec_b[1] = 8'hC0;
            dec_b[2] = 8'hFF;
            dec_b[3] = 8'h80;
            dec_len  = 3'd5;
         end
         6'd17: begin
            dec_b[0] = card_idle ? 8'h05 : 8'h00;
            go_nx    = ~card_idle;
         end
         default: dec_b[0] = r1 | 8'h04;
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      txn_nx   = 8'hFF;
      decode   = 1'b0;
      if (byte_done) begin
         case (state)
            RX_CMD: begin
               if (cnt != 10'd0 || rx_byte[7:6] == 2'b01) begin
                  if (cnt == 10'd5) begin
                     state_nx = NCR;
                     cnt_nx   = 10'd0;
                  end else begin
                     cnt_nx = cnt + 10'd1;
                  end
               end
            end
            NCR: begin
               decode   = 1'b1;
               txn_nx   = dec_b[0];
               state_nx = RESP;
               cnt_nx   = 10'd1;
            end
            RESP: begin
               if (cnt < 10'(resp_len)) begin
                  txn_nx = resp_buf[cnt[2:0]];
                  cnt_nx = cnt + 10'd1;
               end else begin
                  cnt_nx = 10'd0;
                  if (!data_go) begin
                     state_nx = RX_CMD;
                  end else if (NAC == 0) begin
                     txn_nx   = 8'hFE;
                     state_nx = DATA;
                  end else begin
                     state_nx = GAP;
                  end
               end
            end
            GAP: begin
               if (cnt == 10'(NAC - 1)) begin
                  txn_nx   = 8'hFE;
                  state_nx = DATA;
                  cnt_nx   = 10'd0;
               end else begin
                  cnt_nx = cnt + 10'd1;
               end
            end
            DATA: begin
               // token completion plus 512 data bytes; tx_next already holds prefetched data
               if (cnt == 10'd512) begin
                  state_nx = CRC;
                  cnt_nx   = 10'd0;
               end else begin
                  txn_nx = tx_next;
                  cnt_nx = cnt + 10'd1;
               end
            end
            CRC: begin
               if (cnt == 10'd1) begin
                  state_nx = RX_CMD;
                  cnt_nx   = 10'd0;
               end else begin
                  cnt_nx = cnt + 10'd1;
               end
            end
            default: state_nx = RX_CMD;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset || !active) state <= RX_CMD;
      else                  state <= state_nx;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cs_s      <= 2'b11;
         sclk_s    <= 2'b00;
         mosi_s    <= 2'b00;
         sclk_q    <= 1'b0;
         rx_sr     <= '0;
         bit_cnt   <= '0;
         load      <= 1'b0;
         tx_sr     <= 8'hFF;
         tx_next   <= 8'hFF;
         cnt       <= '0;
         cmd_r     <= '0;
         arg_r     <= '0;
         resp_buf  <= '{default: 8'hFF};
         resp_len  <= 3'd1;
         app       <= 1'b0;
         data_go   <= 1'b0;
         polls     <= PW'(INIT_POLLS);
         card_idle <= 1'b1;
         last_cmd  <= '0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         rd_idx    <= '0;
         cap       <= 1'b0;
      end else begin
         cs_s   <= {cs_s[0], spi_cs};
         sclk_s <= {sclk_s[0], spi_sclk};
         mosi_s <= {mosi_s[0], spi_mosi};
         sclk_q <= sclk_s[1];
         mem_rd <= 1'b0;
         cap    <= mem_rd;
         if (!active) begin
            bit_cnt <= '0;
            load    <= 1'b0;
            tx_sr   <= 8'hFF;
            tx_next <= 8'hFF;
            cnt     <= '0;
            rd_idx  <= '0;
         end else begin
            if (rise) begin
               rx_sr   <= rx_byte[6:0];
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) load <= 1'b1;
            end
            if (fall) begin
               if (load) begin
                  tx_sr <= tx_next;
                  load  <= 1'b0;
                  // each byte loaded in DATA prefetches the following one
                  if (state == DATA && !rd_idx[9]) begin
                     mem_rd   <= 1'b1;
                     mem_addr <= {arg_r[ADDR_W-10:0], rd_idx[8:0]};
                     rd_idx   <= rd_idx + 10'd1;
                  end
               end else begin
                  tx_sr <= {tx_sr[6:0], 1'b1};
               end
            end
            if (state != DATA) rd_idx <= '0;
            cnt <= cnt_nx;
            if (cap)            tx_next <= mem_q;
            else if (byte_done) tx_next <= txn_nx;
            if (byte_done && state == RX_CMD) begin
               if (cnt == 10'd0)      cmd_r <= rx_byte[5:0];
               else if (cnt <= 10'd4) arg_r <= ARG_W'({arg_r, rx_byte});
            end
            if (decode) begin
               resp_buf  <= dec_b;
               resp_len  <= dec_len;
               card_idle <= idle_nx;
               app       <= app_nx;
               polls     <= polls_nx;
               data_go   <= go_nx;
               last_cmd  <= cmd_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_card_spi.sv
// tb/tb_sd_card_spi.sv - directed self-checking bench for sd_card_spi
// Drives SPI frames as a mode-0 master and checks responses, block data and memory strobes.
module tb_sd_card_spi;

   localparam int H = 5;

   logic        clock = 1'b0;
   logic        reset, spi_cs, spi_sclk, spi_mosi;
   logic        spi_miso, mem_rd, card_idle;
   logic [23:0] mem_addr;
   logic [7:0]  mem_q = 8'h00;
   logic [5:0]  last_cmd;

   int          checks = 0, failures = 0;
   logic [7:0]  rsp [0:519];
   logic [23:0] rd_log [0:1023];
   int          rd_count = 0, rd_consec_err = 0, rd_cs_err = 0;
   logic        rd_prev = 1'b0;

   sd_card_spi #(.ADDR_W(24), .INIT_POLLS(2), .NAC(1)) dut (
      .clock(clock), .reset(reset), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_q(mem_q), .card_idle(card_idle), .last_cmd(last_cmd)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (mem_rd) mem_q <= mem_addr[7:0] ^ 8'h5A;

   always @(negedge clock) begin
      if (mem_rd) begin
         if (rd_count < 1024) rd_log[rd_count] = mem_addr;
         if (rd_prev) rd_consec_err++;
         if (spi_cs) rd_cs_err++;
         rd_count++;
      end
      rd_prev = mem_rd;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int b = 7; b >= 0; b--) begin
         spi_mosi = tx[b];
         repeat (H) @(negedge clock);
         rx[b] = spi_miso;
         spi_sclk = 1'b1;
         repeat (H) @(negedge clock);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic frame(input logic [5:0] idx, input logic [31:0] arg, input int n, input bit keep_cs);
      logic [7:0] b, r;
      spi_cs = 1'b0;
      repeat (4) @(negedge clock);
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: b = {2'b01, idx};
            1: b = arg[31:24];
            2: b = arg[23:16];
            3: b = arg[15:8];
            4: b = arg[7:0];
            default: b = 8'h95;
         endcase
         spi_byte(b, r);
      end
      for (int i = 0; i < n; i++) begin
         spi_byte(8'hFF, r);
         rsp[i] = r;
      end
      if (!keep_cs) begin
         repeat (4) @(negedge clock);
         spi_cs = 1'b1;
         repeat (4) @(negedge clock);
      end
   endtask

   initial begin
      logic [7:0] r55 [3];
      logic [7:0] r41 [3];
      int s, bad;
      reset = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b1;
      repeat (4) @(negedge clock);
      check("rst_miso", spi_miso, 1);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_idle", card_idle, 1);
      check("rst_last_cmd", last_cmd, 0);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      frame(6'd0, 32'h0, 2, 0);
      check("cmd0_ncr", rsp[0], 8'hFF);
      check("cmd0_r1", rsp[1], 8'h01);
      check("cmd0_idle", card_idle, 1);

      frame(6'd8, 32'h0000_01AA, 6, 0);
      check("cmd8_ncr", rsp[0], 8'hFF);
      check("cmd8_r7", {rsp[1], rsp[2], rsp[3], rsp[4], rsp[5]}, 40'h01_00_00_01_AA);
      check("cmd8_last_cmd", last_cmd, 8);

      frame(6'd17, 32'h0, 5, 0);
      check("cmd17_idle_r1", rsp[1], 8'h05);
      check("cmd17_idle_no_token", {rsp[2], rsp[3], rsp[4]}, 24'hFFFFFF);

      frame(6'd41, 32'h4000_0000, 2, 0);
      check("cmd41_no_app", rsp[1], 8'h05);

      for (int k = 0; k < 3; k++) begin
         frame(6'd55, 32'h0, 2, 0);
         r55[k] = rsp[1];
         frame(6'd41, 32'h4000_0000, 2, 0);
         r41[k] = rsp[1];
      end
      check("init_seq", {r55[0], r41[0], r55[1], r41[1], r55[2], r41[2]}, 48'h01_01_01_01_01_00);
      check("init_idle", card_idle, 0);

      frame(6'd58, 32'h0, 6, 0);
      check("cmd58_r3", {rsp[1], rsp[2], rsp[3], rsp[4], rsp[5]}, 40'h00_C0_FF_80_00);

      s = rd_count;
      frame(6'd17, 32'h0000_0003, 518, 0);
      check("rd_head", {rsp[0], rsp[1], rsp[2], rsp[3]}, 32'hFF_00_FF_FE);
      bad = 0;
      for (int i = 0; i < 512; i++) if (rsp[4 + i] !== (8'(i) ^ 8'h5A)) bad++;
      check("rd_data_errors", bad, 0);
      check("rd_crc", {rsp[516], rsp[517]}, 16'hFFFF);
      check("rd_strobes", rd_count - s, 512);
      bad = 0;
      for (int i = 0; i < 512; i++) if (rd_log[s + i] !== 24'h600 + 24'(i)) bad++;
      check("rd_addr_errors", bad, 0);
      check("rd_first_addr", rd_log[s], 24'h600);
      check("rd_last_addr", rd_log[s + 511], 24'h7FF);

      frame(6'd9, 32'h0, 2, 0);
      check("cmd9_r1", rsp[1], 8'h04);

      s = rd_count;
      frame(6'd17, 32'h0000_0005, 105, 1);
      check("abort_head", {rsp[1], rsp[2], rsp[3]}, 24'h00_FF_FE);
      check("abort_byte100", rsp[104], 8'h3E);
      repeat (4) @(negedge clock);
      spi_cs = 1'b1;
      repeat (20) @(negedge clock);
      check("abort_strobes", rd_count - s, 103);
      frame(6'd58, 32'h0, 6, 0);
      check("abort_cmd58", {rsp[1], rsp[2], rsp[3], rsp[4], rsp[5]}, 40'h00_C0_FF_80_00);
      check("abort_no_more_strobes", rd_count - s, 103);

      frame(6'd8, 32'h0, 2, 1);
      check("pre_rst_r1", rsp[1], 8'h00);
      repeat (4) @(negedge clock);
      check("pre_rst_miso", spi_miso, 0);
      check("pre_rst_idle", card_idle, 0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("mid_rst_miso", spi_miso, 1);
      check("mid_rst_idle", card_idle, 1);
      @(negedge clock);
      reset = 1'b0;
      spi_cs = 1'b1;
      repeat (4) @(negedge clock);
      check("mid_rst_last_cmd", last_cmd, 0);
      frame(6'd0, 32'h0, 2, 0);
      check("post_rst_cmd0", rsp[1], 8'h01);

      check("rd_consecutive", rd_consec_err, 0);
      check("rd_while_cs_high", rd_cs_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sd_card_spi.md
# sd_card_spi

Synthesisable SD-card responder for SPI mode 0. It is the card-side counterpart of the `sd` SPI master: it drives `SPI_MISO` so the AVR boot and FAT code can be exercised in simulation and on the board without a physical card. It decodes 6-byte commands and answers CMD0/8/55/ACMD41/58/17 with SDHC semantics. Block-read data comes from a byte-wide backing memory, either the sim array or the SDRAM read port.

## Interface
Parameters:
- `ADDR_W`, 24: backing-memory byte-address width. Supports 2^(ADDR_W-9) blocks.
- `INIT_POLLS`, 2: number of ACMD41 commands answered 0x01 before the card leaves idle.
- `NAC`, 1: number of 0xFF bytes between the CMD17 R1 response and the 0xFE data token.

Ports:
- `clock`  in  1: system clock. Must be at least 8× the SCLK frequency.
- `reset`  in  1: synchronous, active-high.
- `spi_cs`  in  1: chip select, active-low.
- `spi_sclk`  in  1: SPI clock, asynchronous to `clock`.
- `spi_mosi`  in  1: data from the master.
- `spi_miso`  out  1: data to the master. Idles at 1.
- `mem_addr`  out  ADDR_W: backing-memory byte address.
- `mem_rd`  out  1: one-clock read strobe.
- `mem_q`  in  8: read data, valid on the clock after `mem_rd`.
- `card_idle`  out  1: R1 idle bit.
- `last_cmd`  out  6: index of the most recently decoded command (debug).

## Operation
- **Synchronisation.** `spi_cs`, `spi_sclk` and `spi_mosi` each pass through two flops. Rise and fall are detected from the synchronised SCLK.
- **SPI mode 0.**
  - On each rise: shift MOSI MSB-first into `rx_sr` and increment the 3-bit bit count. The 8th rise completes a byte and sets `load`.
  - On each fall: if `load` is set, `tx_sr <= tx_next` and `load` is cleared; otherwise `tx_sr <= {tx_sr[6:0],1}`.
  - `spi_miso = tx_sr[7]`.
- **CS high.** Bit count is cleared, `tx_sr = 0xFF`, and the FSM returns to RX_CMD. `card_idle`, the app flag and the poll counter are kept.
- **FSM.** `tx_next` defaults to 0xFF and is changed only by the transitions below.
  - RX_CMD: completed bytes with `[7:6]` ≠ 01 are ignored. A byte with `[7:6]` = 01 starts the frame; collect it plus 5 more (cmd, arg[31:0], crc). CRC is ignored. On the 6th byte → NCR.
  - NCR: one 0xFF byte is sent. The response is decoded and queued into a 5-byte response buffer with a length count. → RESP.
  - RESP: send the buffer bytes in order. At the end: CMD17 → GAP; all others → RX_CMD.
  - GAP: send `NAC` bytes of 0xFF, then the token 0xFE → DATA.
  - DATA: send 512 bytes taken from `mem_q`. Byte index runs 0..511. → CRC.
  - CRC: send 0xFF, 0xFF (CRC is not computed) → RX_CMD.
- **Responses.** `i` = `card_idle`.
  - CMD0: R1 0x01. Sets idle, clears the app flag, reloads the poll counter to `INIT_POLLS`.
  - CMD8: R7 = {R1=i, 0x00, 0x00, 0x01, arg[7:0]}.
  - CMD55: R1=i. Sets the app flag for the next command only.
  - ACMD41 (CMD41 with the app flag set): if the poll counter is nonzero, R1 0x01 and decrement it; otherwise R1 0x00 and clear idle.
  - CMD58: R3 = {R1=i, 0xC0, 0xFF, 0x80, 0x00}. OCR has power-up and CCS=1.
  - CMD17 with idle clear: R1 0x00, then the data phase.
  - CMD17 with idle set: R1 0x05, no data phase.
  - Any other command, or CMD41 without the app flag: R1 = i|0x04.
  - The app flag clears after any command other than CMD55.
- **Addressing.** Block addressing: `mem_addr = {arg[ADDR_W-10:0], idx[8:0]}`. Higher argument bits are ignored, so the address wraps modulo 2^(ADDR_W-9) blocks.
- **Prefetch.**
  - `mem_rd` pulses for idx 0 when the token is loaded into `tx_sr`.
  - It pulses for idx n+1 when byte n is loaded.
  - `mem_q` is captured into `tx_next` the clock after each strobe.
  - No strobe is issued after idx 511.

## Timing
- **Reset values:** `spi_miso`=1, `tx_sr`=0xFF, `mem_rd`=0, `mem_addr`=0, `card_idle`=1, `last_cmd`=0, FSM=RX_CMD, poll counter=`INIT_POLLS`, app flag=0.
- **Pin-to-pin:** a SCLK falling edge reaches `spi_miso` after 3 clocks (2 sync stages + 1 register). It must be stable before the next rise, which requires a SCLK half-period of at least 4 clocks.
- **Command latency:** the R1 byte is the 2nd byte clocked after the CRC byte (one NCR byte).
- **Memory handshake:** strobe-to-capture is 2 clocks, always less than one SPI byte time. `mem_rd` is never high on two consecutive clocks.
- **CS abort:** CS rising mid-DATA aborts the transfer. No further `mem_rd` is issued, and the next frame decodes normally.
- **Reset priority:** `reset` overrides any SPI activity on the same clock.

## Test plan
- **Power-up:** reset, then CMD0 {40 00 00 00 00 95} → MISO bytes FF(NCR), 01; `card_idle`=1.
- **CMD8 echo:** CMD8 arg 0x000001AA → 01 00 00 01 AA.
- **Init sequence:** with INIT_POLLS=2, send (CMD55, ACMD41) ×3 → R1 sequence 01,01 / 01,01 / 01,00; `card_idle`=0. Then CMD58 → 00 C0 FF 80 00.
- **Block read:** memory preloaded with byte = addr[7:0] ^ 0x5A; CMD17 arg 3 → 00, FF, FE, then 512 bytes with `mem_addr` 0x600..0x7FF, then FF FF. Each `mem_rd` is exactly one clock.
- **Error paths:**
  - CMD17 sent before init → 05, with no token.
  - CMD41 without a preceding CMD55 → 05.
  - CMD9 after init → 04.
- **Abort:** raise CS after data byte 100 of a CMD17, lower it, send CMD58 → correct R3. No `mem_rd` is issued while CS is high. Mid-frame `reset` → `spi_miso`=1 on the next clock and `card_idle`=1.
